// File: rtl/alu_pkg.sv
// Opcode map, flag bit positions and opcode legality check.
// Shared by the ALU and its arbiter so both agree on a single definition.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHAR = 4'b0110;
  localparam logic [3:0] OP_SHLR = 4'b0111;
  localparam logic [3:0] OP_RL   = 4'b1000;
  localparam logic [3:0] OP_RR   = 4'b1001;
  localparam logic [3:0] OP_AND  = 4'b1011;
  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_NOT  = 4'b1110;
  localparam logic [3:0] OP_MULT = 4'b1111;

  // Bit positions inside the 4-bit {N,Z,C,V} flag vector.
  localparam int unsigned CC_N = 3;
  localparam int unsigned CC_Z = 2;
  localparam int unsigned CC_C = 1;
  localparam int unsigned CC_V = 0;

  // Opcodes 0000, 0011, 0100 and 1010 are unassigned.
  function automatic logic op_legal(input logic [3:0] op);
    return !((op == 4'b0000) || (op == 4'b0011) ||
             (op == 4'b0100) || (op == 4'b1010));
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: on a tie, the port not granted last time wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  // Pick the sole requester, or alternate away from last_grant on a tie.
  always_comb begin
    any   = |valid;
    grant = (valid == 2'b11) ? ~last_grant : valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Round-robin accept, operand latch, multi-cycle hold for MULT,
// and a held per-port response with flags and illegal-opcode error.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_aluop,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic [3:0]  rsp0_cc,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_aluop,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic [3:0]  rsp1_cc,
  output logic        rsp1_err,
  output logic [15:0] alu_valA,
  output logic [15:0] alu_valB,
  output logic [3:0]  alu_aluop,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_cc,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MULW, RESP} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic        grant;
  logic        any;
  logic [3:0]  cnt;
  logic [3:0]  sel_op;
  logic [15:0] sel_a;
  logic [15:0] sel_b;
  logic        owner_ready;
  logic        capture;

  logic        rsp_valid  [2];
  logic [15:0] rsp_result [2];
  logic [3:0]  rsp_cc     [2];
  logic        rsp_err    [2];

  rr_arb2 u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  // Steer the granted request and the owner's response-ready into common nets.
  always_comb begin
    sel_op      = grant ? req1_aluop : req0_aluop;
    sel_a       = grant ? req1_a     : req0_a;
    sel_b       = grant ? req1_b     : req0_b;
    owner_ready = owner ? rsp1_ready : rsp0_ready;
    capture     = (state == EXEC) || ((state == MULW) && (cnt == '0));
  end

  assign req0_ready  = (state == IDLE) && any && !grant;
  assign req1_ready  = (state == IDLE) && any && grant;
  assign busy        = (state != IDLE);

  assign rsp0_valid  = rsp_valid[0];
  assign rsp0_result = rsp_result[0];
  assign rsp0_cc     = rsp_cc[0];
  assign rsp0_err    = rsp_err[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp1_result = rsp_result[1];
  assign rsp1_cc     = rsp_cc[1];
  assign rsp1_err    = rsp_err[1];

  // Arbitration FSM: accept, hold ALU operands, capture into owner's response, await consume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_valA   <= '0;
      alu_valB   <= '0;
      alu_aluop  <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        rsp_valid[i]  <= 1'b0;
        rsp_result[i] <= '0;
        rsp_cc[i]     <= '0;
        rsp_err[i]    <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            owner      <= grant;
            last_grant <= grant;
            alu_aluop  <= sel_op;
            alu_valA   <= sel_a;
            alu_valB   <= sel_b;
            if (!op_legal(sel_op)) begin
              rsp_result[grant] <= '0;
              rsp_cc[grant]     <= '0;
              rsp_err[grant]    <= 1'b1;
              rsp_valid[grant]  <= 1'b1;
              state             <= RESP;
            end else if ((sel_op == OP_MULT) && (MUL_CYCLES > 1)) begin
              cnt   <= MUL_LOAD;
              state <= MULW;
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC, MULW: begin
          // EXEC always captures; MULW counts down and captures once cnt hits zero.
          if (capture) begin
            rsp_result[owner] <= alu_result;
            rsp_cc[owner]     <= alu_cc;
            rsp_err[owner]    <= 1'b0;
            rsp_valid[owner]  <= 1'b1;
            state             <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (owner_ready) begin
            rsp_valid[owner] <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: models the external ALU, runs directed and random
// transactions, and checks timing and values against a latency/value model.
module tb_alu_arbiter;

  localparam int MC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic [3:0]  req0_aluop, rsp0_cc;
  logic [15:0] req0_a, req0_b, rsp0_result;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [3:0]  req1_aluop, rsp1_cc;
  logic [15:0] req1_a, req1_b, rsp1_result;
  logic [15:0] alu_valA, alu_valB, alu_result;
  logic [3:0]  alu_aluop, alu_cc;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.MUL_CYCLES(MC)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_aluop(req0_aluop),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_cc(rsp0_cc), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_aluop(req1_aluop),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_cc(rsp1_cc), .rsp1_err(rsp1_err),
    .alu_valA(alu_valA), .alu_valB(alu_valB), .alu_aluop(alu_aluop),
    .alu_result(alu_result), .alu_cc(alu_cc), .busy(busy)
  );

  // Behavioural ALU: returns {result[15:0], N, Z, C, V}.
  function automatic logic [19:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    logic        c, v;
    r = '0; c = 1'b0; v = 1'b0; w = '0;
    case (op)
      4'h1: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h2: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h5: r = a << b[3:0];
      4'h6: r = $signed(a) >>> b[3:0];
      4'h7: r = a >> b[3:0];
      4'h8: r = (a << b[3:0]) | (a >> (16 - b[3:0]));
      4'h9: r = (a >> b[3:0]) | (a << (16 - b[3:0]));
      4'hB: r = a & b;
      4'hC: r = a | b;
      4'hD: r = a ^ b;
      4'hE: r = ~a;
      4'hF: r = a * b;
      default: r = '0;
    endcase
    return {r, r[15], (r == 16'h0), c, v};
  endfunction

  always_comb {alu_result, alu_cc} = alu_ref(alu_aluop, alu_valA, alu_valB);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    if (p == 1) begin
      req1_valid = v; req1_aluop = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_aluop = op; req0_a = a; req0_b = b;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic [21:0] rsp(input int p);
    return (p == 1) ? {rsp1_valid, rsp1_err, rsp1_result, rsp1_cc}
                    : {rsp0_valid, rsp0_err, rsp0_result, rsp0_cc};
  endfunction

  task automatic set_rsp_ready(input int p, input logic v);
    if (p == 1) rsp1_ready = v; else rsp0_ready = v;
  endtask

  // One single-port transaction: accept, latency, operand hold, value, hold, consume.
  task automatic do_txn(input int p, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input int hold);
    logic        illegal;
    logic [19:0] exp;
    logic [21:0] other_snap, r;
    int          lat, n;
    illegal    = (op == 4'h0) || (op == 4'h3) || (op == 4'h4) || (op == 4'hA);
    exp        = illegal ? 20'h0 : alu_ref(op, a, b);
    lat        = illegal ? 1 : ((op == 4'hF) ? 1 + MC : 2);
    other_snap = rsp(1 - p);
    set_req(p, 1'b1, op, a, b);
    #1;
    n = 0;
    while (!rdy(p) && n < 20) begin tick(); #1; n++; end
    chk("accept_wait", 32'(n < 20), 32'd1);
    tick();
    set_req(p, 1'b0, 4'h0, 16'h0, 16'h0);
    for (int k = 1; k < lat; k++) begin
      r = rsp(p);
      chk("early_valid", 32'(r[21]), 32'd0);
      chk("busy_inflight", 32'(busy), 32'd1);
      chk("alu_hold", {alu_aluop, alu_valA, 12'h0}, {op, a, 12'h0});
      chk("alu_holdB", 32'(alu_valB), 32'(b));
      tick();
    end
    r = rsp(p);
    chk("rsp_valid", 32'(r[21]), 32'd1);
    chk("rsp_err", 32'(r[20]), 32'(illegal));
    chk("rsp_result", 32'(r[19:4]), 32'(exp[19:4]));
    chk("rsp_cc", 32'(r[3:0]), 32'(exp[3:0]));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("rsp_held", 32'(rsp(p)), 32'(r));
    end
    set_rsp_ready(p, 1'b1);
    tick();
    set_rsp_ready(p, 1'b0);
    r = rsp(p);
    chk("rsp_drop", 32'(r[21]), 32'd0);
    chk("idle_after", 32'(busy), 32'd0);
    chk("other_port", 32'(rsp(1 - p)), 32'(other_snap));
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int g[4];
    int ng;
    reset = 1'b1;
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_rsp0", 32'(rsp(0)), 32'd0);
    chk("rst_rsp1", 32'(rsp(1)), 32'd0);
    chk("rst_alu", {alu_aluop, alu_valA, 12'h0}, 32'd0);
    chk("rst_aluB", 32'(alu_valB), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    // Port 0 ADD overflow
    do_txn(0, 4'h1, 16'h7FFF, 16'h0001, 0);
    chk("add_result", 32'(rsp0_result), 32'h8000);
    chk("add_cc", 32'(rsp0_cc), 32'b1001);

    // Port 1 MULT, multi-cycle hold
    do_txn(1, 4'hF, 16'h0003, 16'h0004, 1);
    chk("mult_result", 32'(rsp1_result), 32'h000C);

    // Illegal opcode
    do_txn(0, 4'h3, 16'h1234, 16'h5678, 0);
    chk("illegal_err", 32'(rsp0_err), 32'd1);
    chk("illegal_res", 32'(rsp0_result), 32'd0);

    // Response backpressure with a competing request on port 1
    pulse_reset();
    set_req(0, 1'b1, 4'h1, 16'h0010, 16'h0020);
    set_req(1, 1'b1, 4'hC, 16'h0F00, 16'h00F0);
    #1;
    chk("bp_rdy0", 32'(req0_ready), 32'd1);
    chk("bp_rdy1", 32'(req1_ready), 32'd0);
    tick();
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    chk("bp_rdy1_exec", 32'(req1_ready), 32'd0);
    tick();
    chk("bp_valid", 32'(rsp0_valid), 32'd1);
    chk("bp_result", 32'(rsp0_result), 32'h0030);
    for (int h = 0; h < 5; h++) begin
      tick();
      chk("bp_hold_v", 32'(rsp0_valid), 32'd1);
      chk("bp_hold_r", 32'(rsp0_result), 32'h0030);
      chk("bp_rdy1_hold", 32'(req1_ready), 32'd0);
    end
    rsp0_ready = 1'b1;
    #1;
    chk("bp_no_same_cycle", 32'(req1_ready), 32'd0);
    tick();
    rsp0_ready = 1'b0;
    chk("bp_rdy1_next", 32'(req1_ready), 32'd1);
    tick();
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    tick();
    chk("bp_rsp1_v", 32'(rsp1_valid), 32'd1);
    chk("bp_rsp1_r", 32'(rsp1_result), 32'h0FF0);
    rsp1_ready = 1'b1;
    tick();
    rsp1_ready = 1'b0;

    // Both ports continuously valid: strict alternation starting at port 0
    pulse_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req(0, 1'b1, 4'h2, 16'h0005, 16'h0005);
    set_req(1, 1'b1, 4'hD, 16'hFFFF, 16'h00FF);
    #1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      chk("one_ready", 32'(req0_ready && req1_ready), 32'd0);
      if (rsp0_valid) begin
        chk("sub_result", 32'(rsp0_result), 32'h0000);
        chk("sub_cc", 32'(rsp0_cc), 32'b0100);
      end
      if (rsp1_valid) begin
        chk("xor_result", 32'(rsp1_result), 32'hFF00);
        chk("xor_n", 32'(rsp1_cc[3]), 32'd1);
      end
      if (req0_ready) begin g[ng] = 0; ng++; end
      else if (req1_ready) begin g[ng] = 1; ng++; end
      if (ng < 4) tick();
    end
    chk("grant_count", 32'(ng), 32'd4);
    for (int i = 0; i < ng; i++) chk("grant_order", 32'(g[i]), 32'(i % 2));
    tick();
    set_req(0, 1'b0, 4'h0, 16'h0, 16'h0);
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    for (int c = 0; c < 10; c++) tick();
    chk("drain_busy", 32'(busy), 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;

    // Reset during MULW
    set_req(1, 1'b1, 4'hF, 16'h0007, 16'h0009);
    #1;
    chk("mw_rdy", 32'(req1_ready), 32'd1);
    tick();
    set_req(1, 1'b0, 4'h0, 16'h0, 16'h0);
    tick();
    chk("mw_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mw_rst_busy", 32'(busy), 32'd0);
    chk("mw_rst_alu", {alu_aluop, alu_valA, 12'h0}, 32'd0);
    chk("mw_rst_rsp1", 32'(rsp(1)), 32'd0);
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("mw_no_rsp", 32'(rsp1_valid), 32'd0);
    end
    do_txn(1, 4'hF, 16'h0101, 16'h0003, 0);

    // Randomized single-port transactions
    for (int i = 0; i < 24; i++) begin
      do_txn(int'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound so a stuck DUT still reaches a verdict.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
